// File: rtl/t5_pkg.sv
// Shared definitions for the t5 barrel-pipeline writeback slice.
// Load funct3 encodings, FSM states and hart-count constants.
package t5_pkg;

    localparam int HARTW = 2;
    localparam int NHART = 4;

    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/t5_ldext.sv
// Load data aligner: picks the addressed byte/halfword from a word-aligned
// read and sign- or zero-extends it to XLEN.
module t5_ldext
    import t5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ddat,
    input  logic [1:0]      off,
    input  logic [2:0]      fn3,
    output logic [XLEN-1:0] res
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = ddat[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[off];
    // Halfword loads ignore off[0]; misaligned halves are not split.
    assign half_sel = off[1] ? ddat[31:16] : ddat[15:0];
    assign sext     = ~fn3[2];

    always_comb begin
        res = ddat;
        case (fn3)
            FN3_LB, FN3_LBU: res = {{(XLEN-8){sext & byte_sel[7]}}, byte_sel};
            FN3_LH, FN3_LHU: res = {{(XLEN-16){sext & half_sel[15]}}, half_sel};
            default:         res = ddat;
        endcase
    end

endmodule

// File: rtl/t5_wback.sv
// Writeback stage of the 4-hart barrel pipeline: commits ALU results in one
// cycle, parks one load until the data-memory ack, and flags blocked harts.
module t5_wback
    import t5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              sclk,
    input  logic              srst,
    input  logic              xvld,
    output logic              xrdy,
    input  logic [HARTW-1:0]  xhart,
    input  logic [4:0]        xrd,
    input  logic [XLEN-1:0]   xdat,
    input  logic              xld,
    input  logic [2:0]        xfn3,
    input  logic              dack,
    input  logic [XLEN-1:0]   ddat,
    output logic              mwre,
    output logic [HARTW-1:0]  mhart,
    output logic [4:0]        rd0a,
    output logic [XLEN-1:0]   rd0d,
    output logic [NHART-1:0]  mbsy
);

    state_t state_reg, state_next;

    logic [HARTW-1:0] ld_hart_reg;
    logic [4:0]       ld_rd_reg;
    logic [1:0]       ld_off_reg;
    logic [2:0]       ld_fn3_reg;

    logic             mwre_reg;
    logic [HARTW-1:0] mhart_reg;
    logic [4:0]       rd0a_reg;
    logic [XLEN-1:0]  rd0d_reg;
    logic [NHART-1:0] mbsy_reg;

    logic             alu_take;
    logic             ld_take;
    logic             ld_done;
    logic [XLEN-1:0]  ld_ext;

    assign alu_take = (state_reg == ST_IDLE) && xvld && !xld;
    assign ld_take  = (state_reg == ST_IDLE) && xvld && xld;
    assign ld_done  = (state_reg == ST_WAIT) && dack;

    t5_ldext #(.XLEN(XLEN)) u_ldext (
        .ddat (ddat),
        .off  (ld_off_reg),
        .fn3  (ld_fn3_reg),
        .res  (ld_ext)
    );

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (ld_take) state_next = ST_WAIT;
            ST_WAIT: if (dack)    state_next = ST_IDLE;
            default:              state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        xrdy = (state_reg == ST_IDLE);
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            ld_hart_reg <= '0;
            ld_rd_reg   <= '0;
            ld_off_reg  <= '0;
            ld_fn3_reg  <= '0;
        end else if (ld_take) begin
            ld_hart_reg <= xhart;
            ld_rd_reg   <= xrd;
            ld_off_reg  <= xdat[1:0];
            ld_fn3_reg  <= xfn3;
        end
    end

    // Writes to x0 still update the address/data registers but never pulse mwre.
    always_ff @(posedge sclk) begin
        if (srst) begin
            mwre_reg  <= 1'b0;
            mhart_reg <= '0;
            rd0a_reg  <= '0;
            rd0d_reg  <= '0;
        end else if (alu_take) begin
            mwre_reg  <= (xrd != 5'd0);
            mhart_reg <= xhart;
            rd0a_reg  <= xrd;
            rd0d_reg  <= xdat;
        end else if (ld_done) begin
            mwre_reg  <= (ld_rd_reg != 5'd0);
            mhart_reg <= ld_hart_reg;
            rd0a_reg  <= ld_rd_reg;
            rd0d_reg  <= ld_ext;
        end else begin
            mwre_reg  <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NHART; gi++) begin : g_mbsy
            always_ff @(posedge sclk) begin
                if (srst) begin
                    mbsy_reg[gi] <= 1'b0;
                end else if (ld_take && (xhart == HARTW'(gi))) begin
                    mbsy_reg[gi] <= 1'b1;
                end else if (ld_done && (ld_hart_reg == HARTW'(gi))) begin
                    mbsy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign mwre  = mwre_reg;
    assign mhart = mhart_reg;
    assign rd0a  = rd0a_reg;
    assign rd0d  = rd0d_reg;
    assign mbsy  = mbsy_reg;

endmodule

// File: tb/tb_t5_wback.sv
// Self-checking bench for t5_wback: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_t5_wback;

    localparam int XLEN = 32;

    logic              sclk = 1'b0;
    logic              srst;
    logic              xvld;
    logic              xrdy;
    logic [1:0]        xhart;
    logic [4:0]        xrd;
    logic [XLEN-1:0]   xdat;
    logic              xld;
    logic [2:0]        xfn3;
    logic              dack;
    logic [XLEN-1:0]   ddat;
    logic              mwre;
    logic [1:0]        mhart;
    logic [4:0]        rd0a;
    logic [XLEN-1:0]   rd0d;
    logic [3:0]        mbsy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 sclk = ~sclk;

    t5_wback #(.XLEN(XLEN)) dut (
        .sclk  (sclk),
        .srst  (srst),
        .xvld  (xvld),
        .xrdy  (xrdy),
        .xhart (xhart),
        .xrd   (xrd),
        .xdat  (xdat),
        .xld   (xld),
        .xfn3  (xfn3),
        .dack  (dack),
        .ddat  (ddat),
        .mwre  (mwre),
        .mhart (mhart),
        .rd0a  (rd0a),
        .rd0d  (rd0d),
        .mbsy  (mbsy)
    );

    typedef struct {
        logic [1:0] hart;
        logic [4:0] rd;
        logic [1:0] off;
        logic [2:0] fn3;
    } load_t;

    // Reference model: a queue of outstanding loads plus the last committed write.
    load_t       pend_q[$];
    logic        e_mwre  = 1'b0;
    logic [1:0]  e_mhart = '0;
    logic [4:0]  e_rd0a  = '0;
    logic [31:0] e_rd0d  = '0;

    function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [1:0] off,
                                            input logic [2:0] fn3);
        int unsigned width;
        int unsigned shift;
        bit          sgn;
        logic [31:0] v;
        logic [31:0] mask;
        case (fn3)
            3'b000:  begin width = 8;  sgn = 1'b1; end
            3'b100:  begin width = 8;  sgn = 1'b0; end
            3'b001:  begin width = 16; sgn = 1'b1; end
            3'b101:  begin width = 16; sgn = 1'b0; end
            default: begin width = 32; sgn = 1'b0; end
        endcase
        if (width == 8)       shift = 8 * off;
        else if (width == 16) shift = 16 * (off / 2);
        else                  shift = 0;
        v = d >> shift;
        if (width < 32) begin
            mask = (32'h1 << width) - 32'h1;
            v = v & mask;
            if (sgn && v[width-1]) v = v | ~mask;
        end
        return v;
    endfunction

    always @(posedge sclk) begin
        load_t ld;
        if (srst) begin
            pend_q.delete();
            e_mwre  = 1'b0;
            e_mhart = '0;
            e_rd0a  = '0;
            e_rd0d  = '0;
        end else if (pend_q.size() != 0) begin
            e_mwre = 1'b0;
            if (dack) begin
                ld      = pend_q.pop_front();
                e_mwre  = (ld.rd != 0);
                e_mhart = ld.hart;
                e_rd0a  = ld.rd;
                e_rd0d  = ref_ext(ddat, ld.off, ld.fn3);
            end
        end else if (xvld && !xld) begin
            e_mwre  = (xrd != 0);
            e_mhart = xhart;
            e_rd0a  = xrd;
            e_rd0d  = xdat;
        end else if (xvld && xld) begin
            ld.hart = xhart;
            ld.rd   = xrd;
            ld.off  = xdat[1:0];
            ld.fn3  = xfn3;
            pend_q.push_back(ld);
            e_mwre  = 1'b0;
        end else begin
            e_mwre = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process: every cycle, DUT against model.
    always @(negedge sclk) begin
        logic [3:0] e_mbsy;
        if (cmp_en) begin
            e_mbsy = (pend_q.size() != 0) ? (4'b0001 << pend_q[0].hart) : 4'b0000;
            chk("xrdy",  32'(xrdy),  32'(pend_q.size() == 0));
            chk("mbsy",  32'(mbsy),  32'(e_mbsy));
            chk("mwre",  32'(mwre),  32'(e_mwre));
            if (e_mwre) begin
                chk("mhart", 32'(mhart), 32'(e_mhart));
                chk("rd0a",  32'(rd0a),  32'(e_rd0a));
                chk("rd0d",  rd0d,       e_rd0d);
            end
        end
    end

    task automatic step();
        @(posedge sclk);
        @(negedge sclk);
    endtask

    task automatic idle_inputs();
        xvld = 1'b0; xld = 1'b0; dack = 1'b0;
    endtask

    task automatic issue_load(input logic [1:0] h, input logic [4:0] r, input logic [31:0] a,
                              input logic [2:0] f);
        xvld = 1'b1; xld = 1'b1; xhart = h; xrd = r; xdat = a; xfn3 = f;
        step();
        idle_inputs();
    endtask

    task automatic ack(input logic [31:0] d);
        dack = 1'b1; ddat = d;
        step();
        dack = 1'b0;
    endtask

    initial begin
        logic [31:0] saved;
        srst = 1'b1; xvld = 1'b0; xhart = '0; xrd = '0; xdat = '0; xld = 1'b0;
        xfn3 = '0; dack = 1'b0; ddat = '0;
        @(posedge sclk);
        @(negedge sclk);
        cmp_en = 1'b1;
        step();
        chk("rst_mwre", 32'(mwre), 32'd0);
        chk("rst_mbsy", 32'(mbsy), 32'd0);
        chk("rst_rd0d", rd0d, 32'd0);
        chk("rst_xrdy", 32'(xrdy), 32'd1);
        srst = 1'b0;

        // Model pins against hand-computed extension results.
        chk("ref_lb",  ref_ext(32'h80FF_0000, 2'd3, 3'b000), 32'hFFFF_FF80);
        chk("ref_lhu", ref_ext(32'hABCD_1234, 2'd2, 3'b101), 32'h0000_ABCD);
        chk("ref_lh",  ref_ext(32'hABCD_1234, 2'd2, 3'b001), 32'hFFFF_ABCD);
        chk("ref_lbu", ref_ext(32'h1234_56F0, 2'd0, 3'b100), 32'h0000_00F0);

        xvld = 1'b1; xld = 1'b0; xhart = 2'd2; xrd = 5'd5; xdat = 32'hDEAD_BEEF;
        step();
        $display("TXN alu hart=%0d rd=%0d data=%h mwre=%0d", mhart, rd0a, rd0d, mwre);
        chk("alu_mwre", 32'(mwre), 32'd1);
        chk("alu_mhart", 32'(mhart), 32'd2);
        chk("alu_rd0a", 32'(rd0a), 32'd5);
        chk("alu_rd0d", rd0d, 32'hDEAD_BEEF);

        xrd = 5'd0; xdat = 32'h0000_1234;
        step();
        chk("x0_mwre", 32'(mwre), 32'd0);
        xrd = 5'd1;
        step();
        chk("x1_mwre", 32'(mwre), 32'd1);
        chk("x1_rd0d", rd0d, 32'h0000_1234);
        idle_inputs();

        issue_load(2'd1, 5'd7, 32'h0000_0103, 3'b000);
        for (int i = 0; i < 3; i++) begin
            chk("lb_xrdy", 32'(xrdy), 32'd0);
            chk("lb_mbsy", 32'(mbsy), 32'b0010);
            step();
        end
        ack(32'h80FF_0000);
        $display("TXN load hart=%0d rd=%0d data=%h mwre=%0d", mhart, rd0a, rd0d, mwre);
        chk("lb_mwre", 32'(mwre), 32'd1);
        chk("lb_rd0d", rd0d, 32'hFFFF_FF80);
        chk("lb_mbsy0", 32'(mbsy), 32'd0);
        chk("lb_xrdy1", 32'(xrdy), 32'd1);
        step();
        chk("lb_pulse", 32'(mwre), 32'd0);

        issue_load(2'd3, 5'd9, 32'h0000_0002, 3'b101);
        ack(32'hABCD_1234);
        chk("lhu_rd0d", rd0d, 32'h0000_ABCD);
        issue_load(2'd0, 5'd9, 32'h0000_0002, 3'b001);
        ack(32'hABCD_1234);
        chk("lh_rd0d", rd0d, 32'hFFFF_ABCD);
        issue_load(2'd2, 5'd10, 32'h0000_0001, 3'b010);
        step();
        ack(32'hABCD_1234);
        chk("lw_rd0d", rd0d, 32'hABCD_1234);
        issue_load(2'd2, 5'd0, 32'h0000_0000, 3'b010);
        ack(32'h5555_5555);
        chk("ldx0_mwre", 32'(mwre), 32'd0);
        chk("ldx0_mbsy", 32'(mbsy), 32'd0);

        issue_load(2'd3, 5'd4, 32'h0, 3'b010);
        chk("rstw_mbsy", 32'(mbsy), 32'b1000);
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("rstw_mbsy0", 32'(mbsy), 32'd0);
        chk("rstw_xrdy", 32'(xrdy), 32'd1);
        ack(32'h1111_1111);
        chk("rstw_late", 32'(mwre), 32'd0);

        saved = rd0d;
        ack(32'h2222_2222);
        chk("stray_mwre", 32'(mwre), 32'd0);
        chk("stray_rd0d", rd0d, saved);

        for (int h = 0; h < 4; h++) begin
            xvld = 1'b1; xld = 1'b0; xhart = 2'(h); xrd = 5'(h + 1); xdat = $urandom;
            step();
            chk("b2b_mwre", 32'(mwre), 32'd1);
            chk("b2b_mhart", 32'(mhart), 32'(h));
        end
        idle_inputs();

        // Randomized traffic; the compare process does all the checking.
        for (int c = 0; c < 3000; c++) begin
            srst  = ($urandom_range(0, 299) == 0);
            xvld  = ($urandom_range(0, 9) < 6);
            xld   = ($urandom_range(0, 9) < 4);
            xhart = 2'($urandom_range(0, 3));
            xrd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            xdat  = $urandom;
            xfn3  = 3'($urandom);
            dack  = ($urandom_range(0, 9) < 3);
            ddat  = $urandom;
            step();
            if (mwre && c % 200 == 0)
                $display("TXN rnd hart=%0d rd=%0d data=%h", mhart, rd0a, rd0d);
        end
        srst = 1'b0;
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
